data_mem_responder: RTL and testbench

Slave side of the CPU data-memory port: services `mem_write`, `data_mem_addr`, `data_mem_write` and returns `data_mem_read` in the same cycle, as the single-cycle core requires. It contains the word-addressed data RAM and a small MMIO window with a free-running cycle counter and a buffered output stream. The output stream drains over a valid/ready handshake to the testbench or to a board-level sink. It sits beside the CPU in the top-level SoC, opposite the CPU's data port.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/data_mem_responder_sync_fifo.sv | 66 ++++++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
//   * MMIO register offsets relative to the MMIO window base
//   * STATUS register bit positions
//   * region_e: result of the address decode
//   * pack_status(): builds the STATUS read word
package dmem_pkg;

  localparam logic [31:0] CYCLE_OFS  = 32'h0000_0000;
  localparam logic [31:0] OUT_OFS    = 32'h0000_0004;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0008;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_CYCLE,
    REG_OUT,
    REG_STATUS,
    REG_NONE
  } region_e;

  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w                         = '0;
    w[ST_FULL]                = full;
    w[ST_EMPTY]               = empty;
    w[ST_OVF]                 = ovf;
    w[ST_CNT_LSB +: 8]        = cnt;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// sync_fifo -- single-clock FIFO with a combinational head word.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write request and data; accepted when not full, or when
//                   full but a pop happens in the same cycle
//   pop             read request; ignored when empty
//   full, empty     occupancy flags (state before this cycle's push/pop)
//   count           number of stored entries, 0..DEPTH
//   head            oldest entry; stable until it is popped
// DEPTH must be a power of two (pointers wrap naturally), DEPTH >= 2.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] entry_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = entry_reg[rd_ptr_reg];

  // A pop frees a slot in the same cycle, so a push into a full FIFO that is
  // also being drained is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) entry_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder -- slave side of the single-cycle CPU data port.
// Holds the word-addressed data RAM and a small MMIO window:
//   MMIO_BASE+0x0 CYCLE  free-running cycle counter (loadable)
//   MMIO_BASE+0x4 OUT    store pushes into the output stream FIFO, reads 0
//   MMIO_BASE+0x8 STATUS {cnt[15:8], ovf[2], empty[1], full[0]}; store bit2=1 clears ovf
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_write, data_mem_addr,
//   data_mem_write               CPU store strobe, byte address, store data
//   data_mem_read                load data, combinational in address and state
//   out_valid, out_data,
//   out_ready                    output stream handshake (pop on valid && ready)
// Build option: define DMEM_CYCLE_COUNTER_EN to build the CYCLE counter;
// without it CYCLE reads 0 and stores to it are ignored.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_write,
  output logic [31:0] data_mem_read,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int          IW          = $clog2(MEM_WORDS);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RAM_BYTES   = 33'(MEM_WORDS) * 33'd4;
  localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + CYCLE_OFS;
  localparam logic [31:0] OUT_ADDR    = MMIO_BASE + OUT_OFS;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + STATUS_OFS;

  region_e        region;
  logic [IW-1:0]  ram_idx;
  logic [31:0]    ram_mem [MEM_WORDS];
  logic [31:0]    cycle_val;
  logic           ovf_reg;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           st_out;
  logic           st_status;
  logic           pop;

  // ---------------------------------------------------------------- decode
  // Full 32-bit decode; MMIO registers are matched on the word address so
  // the two low byte-offset bits never matter. RAM takes priority so a
  // window placed inside RAM would never alias anything.
  always_comb begin
    region = REG_NONE;
    if ({1'b0, data_mem_addr} < RAM_BYTES)
      region = REG_RAM;
    else if (data_mem_addr[31:2] == CYCLE_ADDR[31:2])
      region = REG_CYCLE;
    else if (data_mem_addr[31:2] == OUT_ADDR[31:2])
      region = REG_OUT;
    else if (data_mem_addr[31:2] == STATUS_ADDR[31:2])
      region = REG_STATUS;
  end

  assign ram_idx   = data_mem_addr[IW+1:2];
  assign st_out    = mem_write && (region == REG_OUT);
  assign st_status = mem_write && (region == REG_STATUS);

  // ------------------------------------------------------------------- RAM
  // Not reset: contents survive a reset. Asynchronous read keeps the
  // single-cycle core's load latency at zero; a same-cycle load of the
  // stored word sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (mem_write && (region == REG_RAM))
      ram_mem[ram_idx] <= data_mem_write;
  end

  // --------------------------------------------------------- cycle counter
`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_reg;
  logic        st_cycle;

  assign st_cycle = mem_write && (region == REG_CYCLE);

  // A load replaces the increment for that cycle; wrap is natural overflow.
  always_ff @(posedge clk) begin
    if (rst)
      cycle_reg <= '0;
    else if (st_cycle)
      cycle_reg <= data_mem_write;
    else
      cycle_reg <= cycle_reg + 32'd1;
  end

  assign cycle_val = cycle_reg;
`else
  assign cycle_val = '0;
`endif

  // ---------------------------------------------------------- output FIFO
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (st_out),
    .push_data (data_mem_write),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (out_data)
  );

  // Sticky overflow: set only when a push is really dropped (full with no
  // pop to make room). A clear in the same cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (st_status && data_mem_write[ST_OVF])
      ovf_reg <= 1'b0;
    else if (st_out && fifo_full && !pop)
      ovf_reg <= 1'b1;
  end

  // ------------------------------------------------------------- read mux
  always_comb begin
    data_mem_read = '0;
    case (region)
      REG_RAM:    data_mem_read = ram_mem[ram_idx];
      REG_CYCLE:  data_mem_read = cycle_val;
      REG_STATUS: data_mem_read = pack_status(fifo_full, fifo_empty, ovf_reg,
                                              8'(fifo_count));
      default:    data_mem_read = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios followed by random
// traffic, all checked against a queue/array reference model.
module tb_data_mem_responder;

  localparam int          MEM_WORDS = 1024;
  localparam int          DEPTH     = 8;
  localparam logic [31:0] BASE      = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC     = BASE;
  localparam logic [31:0] A_OUT     = BASE + 32'h4;
  localparam logic [31:0] A_ST      = BASE + 32'h8;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_write;
  logic [31:0] data_mem_read;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  always #5 clk = ~clk;

  data_mem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_write      (mem_write),
    .data_mem_addr  (data_mem_addr),
    .data_mem_write (data_mem_write),
    .data_mem_read  (data_mem_read),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_ram [MEM_WORDS];
  bit          m_vld [MEM_WORDS];
  logic [31:0] m_q [$];
  bit          m_ovf;
  logic [31:0] m_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", tag, got, exp);
    end
  endtask

  // Expected load value; returns 0 when the RAM word was never written.
  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    logic [7:0] cnt;
    logic       f, e;
    v = 32'h0;
    if (a < 32'(MEM_WORDS * 4)) begin
      v = m_ram[int'(a >> 2)];
      return m_vld[int'(a >> 2)];
    end
    cnt = 8'(m_q.size());
    f   = (m_q.size() == DEPTH);
    e   = (m_q.size() == 0);
    if ((a & ~32'h3) == A_CYC)     v = CYC_EN ? m_cyc : 32'h0;
    else if ((a & ~32'h3) == A_ST) v = {16'h0, cnt, 5'b0, m_ovf, e, f};
    return 1'b1;
  endfunction

  // One bus transaction: drive, check combinational outputs, clock, update model.
  task automatic cyc(input bit r, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input bit rdy, input string tag);
    logic [31:0] exp;
    bit          known;
    bit          pop;
    bit          was_full;
    rst            = r;
    mem_write      = we;
    data_mem_addr  = a;
    data_mem_write = d;
    out_ready      = rdy;
    #1;
    known = model_read(a, exp);
    if (known) check({tag, ":rd"}, data_mem_read, exp);
    check({tag, ":vld"}, {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) check({tag, ":dat"}, out_data, m_q[0]);
    $display("[TB] %s rst=%0b we=%0b addr=%08h wdata=%08h rdy=%0b rd=%08h vld=%0b",
             tag, r, we, a, d, rdy, data_mem_read, out_valid);
    @(posedge clk);
    if (we && a < 32'(MEM_WORDS * 4)) begin
      m_ram[int'(a >> 2)] = d;
      m_vld[int'(a >> 2)] = 1'b1;
    end
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'h0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      pop      = (m_q.size() != 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (we && (a & ~32'h3) == A_OUT) begin
        if (!was_full || pop) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
      if (we && (a & ~32'h3) == A_ST && d[2]) m_ovf = 1'b0;
      if (CYC_EN) begin
        if (we && (a & ~32'h3) == A_CYC) m_cyc = d;
        else m_cyc = m_cyc + 32'd1;
      end
    end
    #1;
  endtask

  // Combinational look at one address without advancing the clock.
  task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
    mem_write     = 1'b0;
    rst           = 1'b0;
    data_mem_addr = a;
    #1;
    check(tag, data_mem_read, exp);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    for (int i = 0; i < MEM_WORDS; i++) m_vld[i] = 1'b0;

    rst = 1'b1; mem_write = 1'b0; data_mem_addr = 32'h0;
    data_mem_write = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_q.delete(); m_ovf = 1'b0; m_cyc = 32'h0;

    // Reset state
    peek(A_ST, "rst_status", 32'h0000_0002);
    peek(A_CYC, "rst_cycle", 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);

    // RAM round trip; second store checks read-during-write returns old data
    cyc(0, 1, 32'h10, 32'h1111_1111, 0, "ram_init");
    cyc(0, 1, 32'h10, 32'hDEAD_BEEF, 0, "ram_wr");
    peek(32'h10, "ram_rd10", 32'hDEAD_BEEF);
    peek(32'h13, "ram_rd13", 32'hDEAD_BEEF);

    // Cycle counter load and wrap
    cyc(0, 1, A_CYC, 32'hFFFF_FFFE, 0, "cyc_ld");
    peek(A_CYC, "cyc_t0", CYC_EN ? 32'hFFFF_FFFE : 32'h0);
    cyc(0, 0, A_CYC, 32'h0, 0, "cyc_rd");
    peek(A_CYC, "cyc_t1", CYC_EN ? 32'hFFFF_FFFF : 32'h0);
    cyc(0, 0, A_CYC, 32'h0, 0, "cyc_rd");
    peek(A_CYC, "cyc_t2", 32'h0);

    // Stream drain
    for (int i = 1; i <= 3; i++) cyc(0, 1, A_OUT, 32'(i), 0, "push");
    peek(A_ST, "stream_status", 32'h0000_0300);
    for (int i = 1; i <= 3; i++) begin
      check("drain_dat", out_data, 32'(i));
      cyc(0, 0, 32'h2000, 32'h0, 1, "drain");
    end
    check("drain_empty", {31'b0, out_valid}, 32'h0);

    // Overflow: ninth push dropped
    for (int i = 0; i < 9; i++) cyc(0, 1, A_OUT, 32'(100 + i), 0, "ovf_push");
    peek(A_ST, "ovf_status", 32'h0000_0805);
    cyc(0, 1, A_ST, 32'h4, 0, "ovf_clr");
    peek(A_ST, "ovf_cleared", 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      check("ovf_dat", out_data, 32'(100 + i));
      cyc(0, 0, 32'h2000, 32'h0, 1, "ovf_drain");
    end
    check("ovf_no9th", {31'b0, out_valid}, 32'h0);

    // Full with simultaneous pop and push
    for (int i = 0; i < 8; i++) cyc(0, 1, A_OUT, 32'(200 + i), 0, "fill");
    cyc(0, 1, A_OUT, 32'h0000_00AA, 1, "full_pop");
    peek(A_ST, "full_pop_status", 32'h0000_0801);
    for (int i = 0; i < 8; i++) cyc(0, 0, 32'h2000, 32'h0, 1, "fp_drain");

    // Reset mid-stream, including a push on the reset cycle
    for (int i = 0; i < 5; i++) cyc(0, 1, A_OUT, 32'(300 + i), 0, "pre_rst");
    cyc(1, 1, A_OUT, 32'h0000_0055, 0, "rst_mid");
    peek(A_ST, "rstm_status", 32'h0000_0002);
    peek(A_CYC, "rstm_cycle", 32'h0);
    peek(32'h10, "rstm_ram", 32'hDEAD_BEEF);
    check("rstm_valid", {31'b0, out_valid}, 32'h0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
        3:       a = A_CYC | 32'($urandom_range(0, 3));
        4, 5:    a = A_OUT | 32'($urandom_range(0, 3));
        6:       a = A_ST  | 32'($urandom_range(0, 3));
        7:       a = 32'h0000_1000 + 32'($urandom_range(0, 63));
        8:       a = BASE + 32'h0C + 32'($urandom_range(0, 3));
        default: a = 32'h8000_0000 | 32'($urandom);
      endcase
      cyc(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, a,
          $urandom, $urandom_range(0, 2) != 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
